fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_inst_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// instruction width and the bubble instruction shown when the queue is empty.
package fetch_unit_pkg;

  localparam int INST_WIDTH = 16;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Prefetch queue of {instruction, pc} pairs with occupancy count and flush.
// Head is shown combinationally; an empty queue presents NOP at pc 0.
module inst_fifo
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 3,
  parameter int DEPTH    = 2,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [INST_WIDTH-1:0] wr_inst,
  input  logic [PC_WIDTH-1:0]   wr_pc,
  input  logic                  rd_en,
  output logic [INST_WIDTH-1:0] rd_inst,
  output logic [PC_WIDTH-1:0]   rd_pc,
  output logic                  rd_valid,
  output logic [CW-1:0]         count
);

  logic [INST_WIDTH+PC_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_fire;
  logic [INST_WIDTH+PC_WIDTH-1:0] head;

  assign rd_valid = (count_q != '0);
  assign rd_fire  = rd_en & rd_valid;
  assign head     = mem_q[rd_ptr_q];
  assign rd_inst  = rd_valid ? head[INST_WIDTH+PC_WIDTH-1:PC_WIDTH] : NOP_INST;
  assign rd_pc    = rd_valid ? head[PC_WIDTH-1:0] : '0;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(rd_fire);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= {wr_inst, wr_pc};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: run/flush FSM, program counter and ROM read issue,
// feeding a prefetch queue that hands instructions to the decode stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 3,
  parameter int DEPTH    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   rom_addr,
  output logic                  rom_oeb,
  input  logic [INST_WIDTH-1:0] rom_data,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [1:0]            state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0] count;
  logic [UW-1:0] used, limit;
  logic          deq, issue, enq;

  assign deq   = inst_valid & inst_ready;
  // A dequeue this cycle frees a slot in time for the word we issue now.
  assign used  = UW'(count) + UW'(inflight_q);
  assign limit = UW'(DEPTH) + UW'(deq);
  assign issue = (state_q == ST_RUN) && run && !redirect_valid && (used < limit);
  assign enq   = inflight_q & ~redirect_valid;

  assign rom_oeb  = ~issue;
  assign rom_addr = pc_q;
  assign state    = state_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    if (issue) pc_d = pc_q + 1'b1;
    case (state_q)
      ST_RUN:   if (!run && !inflight_q) state_d = ST_IDLE;
      ST_FLUSH: state_d = run ? ST_RUN : ST_IDLE;
      default:  state_d = run ? ST_RUN : ST_IDLE;
    endcase
    if (redirect_valid) begin
      state_d = ST_FLUSH;
      pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  inst_fifo #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .wr_en    (enq),
    .wr_inst  (rom_data),
    .wr_pc    (inflight_pc_q),
    .rd_en    (deq),
    .rd_inst  (inst_out),
    .rd_pc    (inst_pc),
    .rd_valid (inst_valid),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming and stalls,
// hand sequences for backpressure, redirect, run drop and async reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        redirect_valid;
  logic [2:0]  redirect_pc;
  logic [2:0]  rom_addr;
  logic        rom_oeb;
  logic [15:0] rom_data = 16'h0000;
  logic [15:0] inst_out;
  logic [2:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  state;

  int compared   = 0;
  int mismatched = 0;
  int reads_issued = 0;

  typedef struct {
    logic        run;
    logic        ready;
    logic [1:0]  st;
    logic        oeb;
    logic [2:0]  addr;
    logic        valid;
    logic [2:0]  ipc;
    logic [15:0] inst;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  fetch_unit #(.PC_WIDTH(3), .DEPTH(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_oeb        (rom_oeb),
    .rom_data       (rom_data),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .state          (state)
  );

  always #5 clock = ~clock;

  // ROM model: word n holds 16'h1000 + n, one cycle read latency.
  always @(posedge clock) begin
    if (!rom_oeb) rom_data <= 16'h1000 + {13'd0, rom_addr};
    if (reset_n && !rom_oeb) reads_issued <= reads_issued + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic deliver(input string name, input logic [2:0] epc);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (inst_valid && inst_ready) begin
        got = 1'b1;
        $display("deliver %s pc=%0d inst=%h", name, inst_pc, inst_out);
        chk({name, " pc"}, 32'(inst_pc), 32'(epc));
        chk({name, " inst"}, 32'(inst_out), 32'(16'h1000 + 16'(epc)));
      end
      cyc();
    end
    chk({name, " arrived"}, 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming from reset through pc wrap, then a two-cycle stall.
    vec[0] = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0};
    vec[1] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0};
    vec[2] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd1, 1'b0, 3'd0, 16'h0};
    for (int k = 3; k <= 12; k++)
      vec[k] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'((k - 1) % 8), 1'b1,
                 3'((k - 3) % 8), 16'h1000 + 16'((k - 3) % 8)};
    vec[13] = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 3'd2, 16'h1002};
    vec[14] = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 3'd2, 16'h1002};
    vec[15] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd4, 1'b1, 3'd2, 16'h1002};
    vec[16] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd5, 1'b1, 3'd3, 16'h1003};
    vec[17] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd6, 1'b1, 3'd4, 16'h1004};

    reset_n = 1'b0;
    run = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 3'd0;
    #3;
    chk("reset state", 32'(state), 32'd0);
    chk("reset rom_oeb", 32'(rom_oeb), 32'd1);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset inst_out", 32'(inst_out), 32'd0);
    chk("reset inst_pc", 32'(inst_pc), 32'd0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      run = vec[i].run;
      inst_ready = vec[i].ready;
      #1;
      $display("vec %0d state=%0d oeb=%0d addr=%0d valid=%0d pc=%0d inst=%h",
               i, state, rom_oeb, rom_addr, inst_valid, inst_pc, inst_out);
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vec[i].st));
      chk($sformatf("vec%0d rom_oeb", i), 32'(rom_oeb), 32'(vec[i].oeb));
      if (!vec[i].oeb) chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vec[i].addr));
      chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vec[i].valid));
      if (vec[i].valid) begin
        chk($sformatf("vec%0d inst_pc", i), 32'(inst_pc), 32'(vec[i].ipc));
        chk($sformatf("vec%0d inst_out", i), 32'(inst_out), 32'(vec[i].inst));
      end
      cyc();
    end

    // Backpressure from reset: only DEPTH reads, head held stable.
    begin
      int base;
      do_reset();
      base = reads_issued;
      run = 1'b1;
      inst_ready = 1'b0;
      repeat (2) cyc();
      for (int i = 0; i < 5; i++) begin
        #1;
        if (i >= 1) begin
          chk("stall inst_valid", 32'(inst_valid), 32'd1);
          chk("stall inst_pc", 32'(inst_pc), 32'd0);
          chk("stall inst_out", 32'(inst_out), 32'h1000);
          chk("stall rom_oeb", 32'(rom_oeb), 32'd1);
        end
        cyc();
      end
      chk("stall reads issued", 32'(reads_issued - base), 32'd2);
      inst_ready = 1'b1;
      deliver("stall d0", 3'd0);
      deliver("stall d1", 3'd1);
      deliver("stall d2", 3'd2);
    end

    // Redirect with one queued entry and a read in flight.
    do_reset();
    run = 1'b1;
    inst_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 3'd5;
    #1;
    chk("redir pre inst_valid", 32'(inst_valid), 32'd1);
    chk("redir pre inst_pc", 32'(inst_pc), 32'd0);
    chk("redir rom_oeb", 32'(rom_oeb), 32'd1);
    cyc();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("flush inst_valid", 32'(inst_valid), 32'd0);
    chk("flush state", 32'(state), 32'd2);
    chk("flush rom_oeb", 32'(rom_oeb), 32'd1);
    cyc();
    deliver("redir d0", 3'd5);
    deliver("redir d1", 3'd6);
    deliver("redir d2", 3'd7);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 3'd3;
    cyc();
    redirect_pc = 3'd6;
    #1;
    chk("reflush state", 32'(state), 32'd2);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("reflush state2", 32'(state), 32'd2);
    chk("reflush inst_valid", 32'(inst_valid), 32'd0);
    cyc();
    deliver("reflush d0", 3'd6);

    // Dropping run with a read in flight still captures the word.
    do_reset();
    run = 1'b1;
    inst_ready = 1'b0;
    cyc();
    #1;
    chk("rundrop issue", 32'(rom_oeb), 32'd0);
    cyc();
    run = 1'b0;
    #1;
    chk("rundrop rom_oeb", 32'(rom_oeb), 32'd1);
    chk("rundrop state run", 32'(state), 32'd1);
    cyc();
    #1;
    chk("rundrop inst_valid", 32'(inst_valid), 32'd1);
    chk("rundrop inst_pc", 32'(inst_pc), 32'd0);
    chk("rundrop inst_out", 32'(inst_out), 32'h1000);
    cyc();
    #1;
    chk("rundrop state idle", 32'(state), 32'd0);
    chk("rundrop oeb idle", 32'(rom_oeb), 32'd1);
    chk("rundrop valid idle", 32'(inst_valid), 32'd1);
    cyc();

    // Asynchronous reset mid-stream.
    do_reset();
    run = 1'b1;
    inst_ready = 1'b1;
    repeat (5) cyc();
    #2;
    chk("areset pre valid", 32'(inst_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("areset state", 32'(state), 32'd0);
    chk("areset rom_oeb", 32'(rom_oeb), 32'd1);
    chk("areset rom_addr", 32'(rom_addr), 32'd0);
    chk("areset inst_valid", 32'(inst_valid), 32'd0);
    chk("areset inst_out", 32'(inst_out), 32'd0);
    chk("areset inst_pc", 32'(inst_pc), 32'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    deliver("areset d0", 3'd0);
    deliver("areset d1", 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
